// File: rtl/gray_code_pipe.sv
// -----------------------------------------------------------------------------
// gray_code_pipe
//
// Pipelined, parametrised binary <-> Gray code converter with a valid/ready
// handshake on both sides. The direction is chosen per word by in_mode and
// travels with the word to out_mode.
//
//   mode 0 : binary -> Gray, g = b ^ (b >> 1), done entirely in stage 0.
//   mode 1 : Gray -> binary, b[i] = ^g[WIDTH-1:i]. The prefix XOR is resolved
//            MSB-first in chunks of CHUNK = ceil(WIDTH/STAGES) bits, one chunk
//            per stage, so no single stage has a WIDTH-deep XOR chain.
//
// Parameters
//   WIDTH   data width, 2..32
//   STAGES  pipeline register stages, 1..WIDTH (latency = STAGES cycles)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   in_valid    input word present
//   in_ready    block accepts the word this cycle (combinational from out_ready)
//   in_data     binary (mode 0) or Gray (mode 1) word
//   in_mode     0 = binary->Gray, 1 = Gray->binary
//   out_valid   result present
//   out_ready   consumer accepts the result
//   out_data    converted word
//   out_mode    in_mode that travelled with the word
//   xfer_count  16-bit wrapping count of output transfers
//               (only when GRAY_CODE_PIPE_COUNT_EN is defined)
//
// Build option
//   GRAY_CODE_PIPE_COUNT_EN  adds the xfer_count port and its counter.
// -----------------------------------------------------------------------------
module gray_code_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
`ifdef GRAY_CODE_PIPE_COUNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    // Elaboration-time guard against illegal configurations.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("gray_code_pipe: WIDTH must be in 2..32");
        end
        if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
            $error("gray_code_pipe: STAGES must be in 1..WIDTH");
        end
    endgenerate

    // Per-stage payload. For mode 1, data holds already-resolved binary bits
    // above the next chunk and still-unresolved Gray bits below it; acc is
    // the XOR of every Gray bit above the next chunk, i.e. the seed for it.
    typedef struct packed {
        logic             acc;
        logic [WIDTH-1:0] data;
    } word_t;

    // Work done by stage s as the word is loaded into it.
    function automatic word_t stage_xform(input word_t w, input logic mode, input int s);
        word_t r;
        int    hi;
        int    lo;
        logic  a;
        r = w;
        if (mode) begin
            hi = WIDTH - 1 - s * CHUNK;
            lo = WIDTH - (s + 1) * CHUNK;
            if (lo < 0) lo = 0;
            a = w.acc;
            // Late stages may get an empty chunk (hi < lo) when STAGES does
            // not divide WIDTH evenly; they simply pass the word through.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i <= hi && i >= lo) begin
                    a          = a ^ w.data[i];
                    r.data[i]  = a;
                end
            end
            r.acc = a;
        end else if (s == 0) begin
            r.data = w.data ^ (w.data >> 1);
            r.acc  = 1'b0;
        end
        return r;
    endfunction

    // Stage registers
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] mode_q;
    word_t             stage_q [STAGES];

    // Handshake chain and upstream view of every stage
    logic [STAGES:0]   adv;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_mode;
    word_t             up_w    [STAGES];

    // A stage may load when it is empty or when the stage below it moves on,
    // so bubbles collapse and an empty stage always accepts.
    always_comb begin
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k + 1];
        end
    end

    // NOTE: every output of a combinational block is assigned on every path
    // (here each array element is written unconditionally), otherwise a
    // latch is inferred to remember the old value.
    always_comb begin
        up_v[0]    = in_valid;
        up_mode[0] = in_mode;
        up_w[0]    = {1'b0, in_data};
        for (int k = 1; k < STAGES; k++) begin
            up_v[k]    = v_q[k - 1];
            up_mode[k] = mode_q[k - 1];
            up_w[k]    = stage_q[k - 1];
        end
    end

    // NOTE: the data registers are reset along with the valid bits because
    // out_data and out_mode must read 0 after reset, not just out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            mode_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: state uses non-blocking assignments so every stage reads
            // its upstream neighbour's value from before this edge.
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= up_v[k];
                    // Payload only moves with a real word, so a bubble never
                    // disturbs the data sitting in a stage.
                    if (up_v[k]) begin
                        stage_q[k] <= stage_xform(up_w[k], up_mode[k], k);
                        mode_q[k]  <= up_mode[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];
    assign out_data  = stage_q[STAGES-1].data;
    assign out_mode  = mode_q[STAGES-1];

`ifdef GRAY_CODE_PIPE_COUNT_EN
    // Counts completed output transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_code_pipe.sv
// -----------------------------------------------------------------------------
// tb_gray_code_pipe
//
// Self-checking bench for gray_code_pipe. Three instances share clk/rst_n:
//   m_  : WIDTH=8, STAGES=2  (directed table, backpressure, streams, reset)
//   w3_ : WIDTH=3, STAGES=1  (legacy 3-bit sweep)
//   s3_ : WIDTH=8, STAGES=3  (0..255 round trip)
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later
// so handshakes are evaluated before the next rising edge.
// -----------------------------------------------------------------------------
module tb_gray_code_pipe;

    localparam int M_STAGES = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // main instance
    logic       m_in_valid, m_in_ready, m_in_mode, m_out_valid, m_out_ready, m_out_mode;
    logic [7:0] m_in_data, m_out_data;
    // 3-bit instance
    logic       w3_in_valid, w3_in_ready, w3_in_mode, w3_out_valid, w3_out_ready, w3_out_mode;
    logic [2:0] w3_in_data, w3_out_data;
    // 3-stage instance
    logic       s3_in_valid, s3_in_ready, s3_in_mode, s3_out_valid, s3_out_ready, s3_out_mode;
    logic [7:0] s3_in_data, s3_out_data;
`ifdef GRAY_CODE_PIPE_COUNT_EN
    logic [15:0] m_xfer_count, w3_xfer_count, s3_xfer_count;
`endif

    gray_code_pipe #(.WIDTH(8), .STAGES(M_STAGES)) u_main (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data), .in_mode(m_in_mode),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data), .out_mode(m_out_mode)
`ifdef GRAY_CODE_PIPE_COUNT_EN
        , .xfer_count(m_xfer_count)
`endif
    );

    gray_code_pipe #(.WIDTH(3), .STAGES(1)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w3_in_valid), .in_ready(w3_in_ready), .in_data(w3_in_data), .in_mode(w3_in_mode),
        .out_valid(w3_out_valid), .out_ready(w3_out_ready), .out_data(w3_out_data), .out_mode(w3_out_mode)
`ifdef GRAY_CODE_PIPE_COUNT_EN
        , .xfer_count(w3_xfer_count)
`endif
    );

    gray_code_pipe #(.WIDTH(8), .STAGES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s3_in_valid), .in_ready(s3_in_ready), .in_data(s3_in_data), .in_mode(s3_in_mode),
        .out_valid(s3_out_valid), .out_ready(s3_out_ready), .out_data(s3_out_data), .out_mode(s3_out_mode)
`ifdef GRAY_CODE_PIPE_COUNT_EN
        , .xfer_count(s3_xfer_count)
`endif
    );

    typedef struct {
        logic [7:0] din;
        logic       mode;
        logic [7:0] dout;
    } vec_t;

    vec_t       vecs [10];
    logic [2:0] w3_exp [8];
    logic [7:0] s3_src [256];
    logic [7:0] s3_dst [256];
    logic [8:0] sb [$];          // {mode, expected data} in arrival order

    // Reference: Gray encode by shift/XOR, Gray decode by log-step prefix XOR.
    function automatic logic [7:0] ref_conv(input logic [7:0] d, input logic m);
        logic [7:0] b;
        if (!m) return d ^ (d >> 1);
        b = d;
        for (int s = 1; s < 8; s = s * 2) b = b ^ (b >> s);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated word through the main instance with out_ready held high.
    task automatic single(input logic [7:0] d, input logic m, input logic [7:0] e, input string tag);
        int lat;
        @(negedge clk);
        m_in_valid = 1'b1; m_in_data = d; m_in_mode = m; m_out_ready = 1'b1;
        #1 check($sformatf("%s in_ready", tag), 32'(m_in_ready), 1);
        @(negedge clk);                 // accepting edge N has passed
        m_in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        // out_valid now high, so the output transfer happens at edge N+lat
        check($sformatf("%s latency", tag), 32'(lat), M_STAGES);
        check($sformatf("%s data", tag), 32'(m_out_data), 32'(e));
        check($sformatf("%s mode", tag), 32'(m_out_mode), 32'(m));
        @(negedge clk);
        check($sformatf("%s no duplicate", tag), 32'(m_out_valid), 0);
    endtask

    // Streams n words through the main instance against the scoreboard.
    task automatic run_stream(input int n, input int vpct, input int rpct, input bit alt,
                              input string tag, output int cycles);
        int         sent, got, cyc;
        logic       stall_prev, m;
        logic [7:0] data_prev, d;
        logic [8:0] e;
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; data_prev = '0; d = '0; m = 1'b0;
        sb.delete();
        while (got < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            cyc++;
            m_in_valid = 1'b0;
            if (sent < n && $urandom_range(99) < vpct) begin
                d = 8'($urandom);
                m = alt ? sent[0] : 1'($urandom);
                m_in_valid = 1'b1; m_in_data = d; m_in_mode = m;
            end
            m_out_ready = ($urandom_range(99) < rpct);
            #1;
            check($sformatf("%s in_ready c%0d", tag, cyc), 32'(m_in_ready),
                  32'((sb.size() < M_STAGES) || m_out_ready));
            if (stall_prev) begin
                check($sformatf("%s hold valid c%0d", tag, cyc), 32'(m_out_valid), 1);
                check($sformatf("%s hold data c%0d", tag, cyc), 32'(m_out_data), 32'(data_prev));
            end
            if (m_out_valid && m_out_ready) begin
                check($sformatf("%s output expected c%0d", tag, cyc), 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("%s data w%0d", tag, got), 32'(m_out_data), 32'(e[7:0]));
                    check($sformatf("%s mode w%0d", tag, got), 32'(m_out_mode), 32'(e[8]));
                    got++;
                end
            end
            if (m_in_valid && m_in_ready) begin
                sb.push_back({m, ref_conv(d, m)});
                sent++;
            end
            stall_prev = m_out_valid && !m_out_ready;
            data_prev  = m_out_data;
        end
        check($sformatf("%s words out", tag), 32'(got), 32'(n));
        cycles = cyc;
    endtask

    task automatic s3_stream(input logic m);
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < 256 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            s3_out_ready = 1'b1;
            s3_in_valid  = (sent < 256);
            s3_in_data   = s3_src[sent < 256 ? sent : 0];
            s3_in_mode   = m;
            #1;
            if (s3_out_valid) begin
                s3_dst[got] = s3_out_data;
                check($sformatf("s3 mode%0d w%0d", m, got), 32'(s3_out_mode), 32'(m));
                got++;
            end
            if (s3_in_valid && s3_in_ready) sent++;
        end
        check($sformatf("s3 mode%0d count", m), 32'(got), 256);
    endtask

    initial begin
        int cyc, got, sent, emitted, fires;
        logic [7:0] bp_d [4];
        logic       bp_m [4];

        vecs[0] = '{8'h2D, 1'b0, 8'h3B};
        vecs[1] = '{8'h3B, 1'b1, 8'h2D};
        vecs[2] = '{8'h00, 1'b0, 8'h00};
        vecs[3] = '{8'h00, 1'b1, 8'h00};
        vecs[4] = '{8'hFF, 1'b0, 8'h80};
        vecs[5] = '{8'h80, 1'b1, 8'hFF};
        vecs[6] = '{8'hFF, 1'b1, 8'hAA};
        vecs[7] = '{8'h55, 1'b0, 8'h7F};
        vecs[8] = '{8'h7F, 1'b1, 8'h55};
        vecs[9] = '{8'hAA, 1'b0, 8'hFF};
        w3_exp  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        bp_d    = '{8'h12, 8'h34, 8'h56, 8'h78};
        bp_m    = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        m_in_valid = 0;  m_in_data = '0;  m_in_mode = 0;  m_out_ready = 0;
        w3_in_valid = 0; w3_in_data = '0; w3_in_mode = 0; w3_out_ready = 0;
        s3_in_valid = 0; s3_in_data = '0; s3_in_mode = 0; s3_out_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset out_valid", 32'(m_out_valid), 0);
        check("reset in_ready", 32'(m_in_ready), 1);
        check("reset out_data", 32'(m_out_data), 0);
        check("reset out_mode", 32'(m_out_mode), 0);
        check("reset w3 out_valid", 32'(w3_out_valid), 0);
        check("reset s3 in_ready", 32'(s3_in_ready), 1);
`ifdef GRAY_CODE_PIPE_COUNT_EN
        check("reset xfer_count", 32'(m_xfer_count), 0);
`endif

        // Directed table
        for (int i = 0; i < 10; i++)
            single(vecs[i].din, vecs[i].mode, vecs[i].dout, $sformatf("vec%0d", i));

        // Legacy 3-bit sweep, latency 1
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            w3_out_ready = 1'b1;
            w3_in_valid  = (c < 8);
            w3_in_data   = 3'(c);
            w3_in_mode   = 1'b0;
            #1;
            check($sformatf("w3 out_valid c%0d", c), 32'(w3_out_valid), 32'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8)
                check($sformatf("w3 data in%0d", c - 1), 32'(w3_out_data), 32'(w3_exp[c-1]));
        end
        @(negedge clk);
        w3_in_valid = 1'b0;

        // Round trip 0..255 through the 3-stage instance
        for (int i = 0; i < 256; i++) s3_src[i] = 8'(i);
        s3_stream(1'b0);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("s3 gray %0d", i), 32'(s3_dst[i]), 32'(ref_conv(8'(i), 1'b0)));
            s3_src[i] = s3_dst[i];
        end
        s3_stream(1'b1);
        for (int i = 0; i < 256; i++)
            check($sformatf("s3 identity %0d", i), 32'(s3_dst[i]), 32'(i));

        // Backpressure: 4 words offered against a stalled consumer
        sent = 0; got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            m_out_ready = (c >= 6);
            m_in_valid  = (sent < 4);
            m_in_data   = bp_d[sent < 4 ? sent : 0];
            m_in_mode   = bp_m[sent < 4 ? sent : 0];
            #1;
            if (c == 5) begin
                check("bp accepted while stalled", 32'(sent), M_STAGES);
                check("bp in_ready low when full", 32'(m_in_ready), 0);
            end
            if (c == 6) check("bp in_ready with out_ready", 32'(m_in_ready), 1);
            if (c < 6 && m_out_valid)
                check($sformatf("bp hold c%0d", c), 32'(m_out_data), 32'(ref_conv(bp_d[0], bp_m[0])));
            if (m_out_valid && m_out_ready && got < 4) begin
                check($sformatf("bp data w%0d", got), 32'(m_out_data), 32'(ref_conv(bp_d[got], bp_m[got])));
                check($sformatf("bp mode w%0d", got), 32'(m_out_mode), 32'(bp_m[got]));
                got++;
            end
            if (m_in_valid && m_in_ready) sent++;
        end
        check("bp words out", 32'(got), 4);
        @(negedge clk);
        m_in_valid = 1'b0;
        #1 check("bp no duplicate", 32'(m_out_valid), 0);

        // Alternating modes at full rate: n words take n+STAGES cycles
        run_stream(32, 100, 100, 1'b1, "alt", cyc);
        check("alt throughput cycles", 32'(cyc), 32'(32 + M_STAGES));

        // Random valid/ready
        run_stream(400, 70, 60, 1'b0, "rnd", cyc);

        // Reset with two words in flight
        @(negedge clk);
        m_out_ready = 1'b0; m_in_valid = 1'b1; m_in_data = 8'h11; m_in_mode = 1'b0;
        @(negedge clk);
        m_in_data = 8'h22;
        @(negedge clk);
        m_in_valid = 1'b0;
        #1 check("rst pre out_valid", 32'(m_out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(m_out_valid), 0);
        check("rst out_data", 32'(m_out_data), 0);
        check("rst out_mode", 32'(m_out_mode), 0);
`ifdef GRAY_CODE_PIPE_COUNT_EN
        check("rst xfer_count", 32'(m_xfer_count), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        m_out_ready = 1'b1;
        #1 check("rst in_ready after release", 32'(m_in_ready), 1);
        emitted = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (m_out_valid) emitted++;
        end
        check("rst nothing emitted", 32'(emitted), 0);

`ifdef GRAY_CODE_PIPE_COUNT_EN
        // 70000 output transfers, with a blocked cycle every 64th cycle
        fires = 0; cyc = 0;
        while (fires < 70000 && cyc < 80000) begin
            @(negedge clk);
            m_in_valid = 1'b1; m_in_data = 8'(cyc); m_in_mode = 1'b0;
            m_out_ready = ((cyc % 64) != 63);
            #1 if (m_out_valid && m_out_ready) fires++;
            cyc++;
        end
        @(negedge clk);
        m_in_valid = 1'b0; m_out_ready = 1'b0;
        #1 check("cnt transfers seen", 32'(fires), 70000);
        check("cnt value", 32'(m_xfer_count), 70000 % 65536);
        repeat (3) @(negedge clk);
        #1 check("cnt blocked not counted", 32'(m_xfer_count), 70000 % 65536);
        @(negedge clk);
        m_out_ready = 1'b1;
        repeat (4) @(negedge clk);
`endif

        single(8'h2D, 1'b0, 8'h3B, "post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
